// File: rtl/tt_um_jleugeri_ttt_sequencer.sv
// Timestep sequencer for the ticktocktokens processor: buffers token events, then on each tick
// drains them as add ops, issues tally and countdown, and latches the resulting start/stop flags.
module tt_um_jleugeri_ttt_sequencer #(
    parameter int FIFO_DEPTH       = 4,
    parameter int DATA_BITS        = 8,
    parameter int INSTRUCTION_BITS = 4,
    parameter int PROC_LATENCY     = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        evt_valid,
    output logic                        evt_ready,
    input  logic [7:0]                  evt_data,
    input  logic                        tick,
    output logic                        busy,
    output logic                        step_done,
    output logic                        token_start,
    output logic                        token_stop,
    output logic                        tick_overrun,
    output logic [INSTRUCTION_BITS-1:0] proc_instruction,
    output logic [DATA_BITS-1:0]        proc_data,
    input  logic                        proc_token_start,
    input  logic                        proc_token_stop
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = (PROC_LATENCY > 1) ? $clog2(PROC_LATENCY) : 1;

    localparam logic [INSTRUCTION_BITS-1:0] OP_IDLE  = INSTRUCTION_BITS'(4'b0011);
    localparam logic [INSTRUCTION_BITS-1:0] OP_TALLY = INSTRUCTION_BITS'(4'b1000);
    localparam logic [INSTRUCTION_BITS-1:0] OP_COUNT = INSTRUCTION_BITS'(4'b1001);
    localparam logic [WAIT_W-1:0]           WAIT_INIT = WAIT_W'(PROC_LATENCY - 1);
    localparam logic [CNT_W-1:0]            CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAIN = 3'd1,
        TALLY = 3'd2,
        TWAIT = 3'd3,
        COUNT = 3'd4,
        CWAIT = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t state, state_d;

    // Event FIFO. Handshake: a word transfers on a rising clk edge where evt_valid && evt_ready;
    // evt_ready reflects the stored count only and is never raised early by a same-cycle pop.
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push, pop;
    logic [7:0]       head;

    assign evt_ready = (count < CNT_FULL);
    assign push      = evt_valid && evt_ready;
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= evt_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sequencer registers. Ops are loaded one cycle ahead so each state's op is visible
    // on proc_instruction during that state.
    logic [CNT_W-1:0]            drain_left, drain_left_d;
    logic [WAIT_W-1:0]           wait_cnt, wait_cnt_d;
    logic                        start_smp, start_smp_d;
    logic                        token_start_d, token_stop_d, step_done_d;
    logic [INSTRUCTION_BITS-1:0] op_d;
    logic [DATA_BITS-1:0]        data_d;
    logic                        pending;
    logic                        go;

    assign go   = tick || pending;
    assign busy = (state != IDLE);

    always_comb begin
        state_d       = state;
        pop           = 1'b0;
        op_d          = OP_IDLE;
        data_d        = '0;
        drain_left_d  = drain_left;
        wait_cnt_d    = wait_cnt;
        start_smp_d   = start_smp;
        token_start_d = token_start;
        token_stop_d  = token_stop;
        step_done_d   = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    if (count != '0) begin
                        pop          = 1'b1;
                        op_d         = INSTRUCTION_BITS'({3'b000, head[7]});
                        data_d       = DATA_BITS'(head[6:0]);
                        drain_left_d = count - 1'b1;
                        state_d      = DRAIN;
                    end else begin
                        op_d    = OP_TALLY;
                        state_d = TALLY;
                    end
                end
            end
            DRAIN: begin
                // drain_left counts entries still owed from the snapshot, so late pushes stay queued
                if (drain_left != '0) begin
                    pop          = 1'b1;
                    op_d         = INSTRUCTION_BITS'({3'b000, head[7]});
                    data_d       = DATA_BITS'(head[6:0]);
                    drain_left_d = drain_left - 1'b1;
                end else begin
                    op_d    = OP_TALLY;
                    state_d = TALLY;
                end
            end
            TALLY: begin
                wait_cnt_d = WAIT_INIT;
                state_d    = TWAIT;
            end
            TWAIT: begin
                if (wait_cnt == '0) begin
                    start_smp_d = proc_token_start;
                    op_d        = OP_COUNT;
                    state_d     = COUNT;
                end else begin
                    wait_cnt_d = wait_cnt - 1'b1;
                end
            end
            COUNT: begin
                wait_cnt_d = WAIT_INIT;
                state_d    = CWAIT;
            end
            CWAIT: begin
                if (wait_cnt == '0) begin
                    token_start_d = start_smp;
                    token_stop_d  = proc_token_stop;
                    step_done_d   = 1'b1;
                    state_d       = DONE;
                end else begin
                    wait_cnt_d = wait_cnt - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            drain_left       <= '0;
            wait_cnt         <= '0;
            start_smp        <= 1'b0;
            token_start      <= 1'b0;
            token_stop       <= 1'b0;
            step_done        <= 1'b0;
            proc_instruction <= OP_IDLE;
            proc_data        <= '0;
        end else begin
            state            <= state_d;
            drain_left       <= drain_left_d;
            wait_cnt         <= wait_cnt_d;
            start_smp        <= start_smp_d;
            token_start      <= token_start_d;
            token_stop       <= token_stop_d;
            step_done        <= step_done_d;
            proc_instruction <= op_d;
            proc_data        <= data_d;
        end
    end

    // One tick may wait behind the running step; any further tick is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending      <= 1'b0;
            tick_overrun <= 1'b0;
        end else if (state == IDLE) begin
            pending <= pending && tick;
        end else if (tick) begin
            if (pending) begin
                tick_overrun <= 1'b1;
            end else begin
                pending <= 1'b1;
            end
        end
    end

endmodule
